secuenciador_giro: RTL and testbench
====================================

Name: secuenciador_giro

Overview:
- Closed-loop sequencer for the refrigeration fan/compressor.
- Periodically triggers an ADC conversion and latches the temperature.
- Compares it with the keypad setpoint and derives a 2-bit target speed level with hysteresis.
- Ramps the applied level one step at a time with a minimum dwell, and drives the motor PWM. Sits between the ADC interface, keypad register and motor driver.

Parameters:
- TICK_DIV, 50000, clk cycles per time-base tick (1 ms at 50 MHz).
- SAMPLE_TICKS, 100, ticks between conversion requests.
- ADC_TIMEOUT, 10, ticks allowed for adc_done after adc_start.
- DWELL_TICKS, 2000, minimum ticks between consecutive giro steps.
- UMBRAL_1, 20, upper diff bound of level 1.
- UMBRAL_2, 40, upper diff bound of level 2.
- HYST, 2, hysteresis margin applied on level decrease.
- DUTY_1, 85, PWM duty (/255) at level 1.
- DUTY_2, 170, PWM duty at level 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- adc  in  8  conversion result, valid when adc_done=1
- adc_done  in  1  one-cycle pulse, conversion complete
- teclado  in  8  setpoint from keypad, sampled in EVALUA
- adc_start  out  1  one-cycle conversion request
- nivel_obj  out  2  target level after hysteresis
- giro  out  2  applied speed level
- pwm_out  out  1  motor PWM
- fallo  out  1  ADC timeout flag

Behaviour:
- Reset (rst=1 on a clk edge): all outputs 0; FSM to ESPERA; tick, sample, timeout and dwell counters 0; PWM counter 0, active duty 0.
- Tick: a divider counts 0..TICK_DIV-1; tick pulses for one cycle on wrap.
- FSM states ESPERA, CONVERSION, EVALUA:
  - ESPERA: counts ticks. After SAMPLE_TICKS ticks it moves to CONVERSION, pulses adc_start for exactly the entry cycle, and clears the timeout counter.
  - CONVERSION, adc_done=1: latch adc, go to EVALUA.
  - CONVERSION, ADC_TIMEOUT ticks elapsed without adc_done: fallo=1, nivel_obj=3 (fail-safe max cooling), back to ESPERA.
  - adc_done and timeout in the same cycle: adc_done wins.
  - adc_done outside CONVERSION is ignored.
- EVALUA (exactly 1 cycle):
  - diff = (adc_l > teclado) ? adc_l - teclado : 0. 8-bit, never wraps.
  - lvl(x) = 0 if x==0; 1 if x<=UMBRAL_1; 2 if x<=UMBRAL_2; else 3.
  - Increase: if lvl(diff) > nivel_obj, nivel_obj = lvl(diff) immediately.
  - Decrease: if lvl(diff) < nivel_obj, nivel_obj = lvl(min(diff+HYST,255)), and only if that value is < nivel_obj; otherwise hold.
  - fallo clears. Return to ESPERA.
- Ramp:
  - The dwell counter increments on each tick, saturating at DWELL_TICKS.
  - When giro != nivel_obj and dwell == DWELL_TICKS, giro moves ±1 toward nivel_obj and dwell resets to 0.
  - Never jumps more than one level per step.
  - Because dwell resets to 0, the first step after reset occurs DWELL_TICKS ticks after reset (compressor protection).
- PWM:
  - 8-bit counter increments every clk and wraps 255→0.
  - Duty for giro 0/1/2/3 = 0/DUTY_1/DUTY_2/255.
  - The new duty is loaded only on the cycle the counter is 255 (glitch-free).
  - pwm_out = cnt < duty, except duty 255 gives constant 1 and duty 0 gives constant 0.
- Reset mid-conversion or mid-ramp: everything returns to reset values next edge; any in-flight conversion result is discarded.

Decomposition:
- Shared package holds:
  - level constants NIVEL_0..NIVEL_3 (2'b00..2'b11), so they match the existing controller encoding;
  - FSM state encoding;
  - default thresholds and duties.
- Sub-module generador_pwm:
  - inputs: clk, rst, duty[7:0];
  - output: pwm_out;
  - owns the counter and the wrap-synchronous duty load.

Test Plan:
Bench parameters: TICK_DIV=4, SAMPLE_TICKS=2, ADC_TIMEOUT=3, DWELL_TICKS=2, HYST=2.
1. Reset then idle: adc_start pulses once 8 cycles after reset release, 1 cycle wide; all other outputs are 0 throughout.
2. teclado=50, adc=75 returned 2 cycles after adc_start:
   - nivel_obj=2 the cycle after EVALUA;
   - giro goes 0→1 at the first dwell expiry, then 1→2 two ticks later;
   - duty reaches 170: pwm_out high 170 of every 256 cycles.
3. Hysteresis, nivel_obj=2:
   - adc-teclado=19 → nivel_obj stays 2 (19+2=21 → level 2);
   - next sample diff=18 → nivel_obj=1.
4. Underflow: teclado=200, adc=10 → diff=0, nivel_obj=0, giro ramps down one step per dwell to 0, pwm_out constant 0.
5. Timeout: adc_done never asserted → fallo=1 after 3 ticks, nivel_obj=3, giro ramps to 3, pwm_out constant 1; the next good conversion clears fallo.
6. Corner cases:
   - adc_done coincident with the timeout tick → result accepted, fallo stays 0;
   - rst asserted during CONVERSION → outputs 0 next edge, a late adc_done is ignored.

Source files
------------

// File: rtl/secuenciador_giro_pkg.sv
// secuenciador_giro_pkg: shared level codes, FSM encoding and default tuning for the fan sequencer
package secuenciador_giro_pkg;
    typedef logic [1:0] nivel_t;
    localparam nivel_t NIVEL_0 = 2'b00;
    localparam nivel_t NIVEL_1 = 2'b01;
    localparam nivel_t NIVEL_2 = 2'b10;
    localparam nivel_t NIVEL_3 = 2'b11;
    localparam logic [1:0] ESPERA     = 2'd0;
    localparam logic [1:0] CONVERSION = 2'd1;
    localparam logic [1:0] EVALUA     = 2'd2;
    localparam int unsigned TICK_DIV_DEF     = 50000;
    localparam int unsigned SAMPLE_TICKS_DEF = 100;
    localparam int unsigned ADC_TIMEOUT_DEF  = 10;
    localparam int unsigned DWELL_TICKS_DEF  = 2000;
    localparam int unsigned UMBRAL_1_DEF     = 20;
    localparam int unsigned UMBRAL_2_DEF     = 40;
    localparam int unsigned HYST_DEF         = 2;
    localparam int unsigned DUTY_1_DEF       = 85;
    localparam int unsigned DUTY_2_DEF       = 170;

    function automatic nivel_t nivel_de(input logic [7:0] x, input logic [7:0] u1, input logic [7:0] u2);
        return x == 8'd0 ? NIVEL_0 : x <= u1 ? NIVEL_1 : x <= u2 ? NIVEL_2 : NIVEL_3;
    endfunction

    function automatic logic [7:0] duty_de(input nivel_t n, input logic [7:0] d1, input logic [7:0] d2);
        return n == NIVEL_0 ? 8'd0 : n == NIVEL_1 ? d1 : n == NIVEL_2 ? d2 : 8'hFF;
    endfunction
endpackage

// File: rtl/secuenciador_giro_pwm.sv
// generador_pwm: 8-bit free-running PWM whose duty is only reloaded at counter wrap
module generador_pwm (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty,
    output logic       pwm_out
);
    logic [7:0] cnt_q, cnt_d, duty_q, duty_d;

    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        duty_d = cnt_q == 8'hFF ? duty : duty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    assign pwm_out = duty_q == 8'hFF || cnt_q < duty_q;
endmodule

// File: rtl/secuenciador_giro.sv
// secuenciador_giro: samples temperature via ADC, derives a hysteretic fan level and ramps the motor PWM
module secuenciador_giro
    import secuenciador_giro_pkg::*;
#(
    parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
    parameter int unsigned SAMPLE_TICKS = SAMPLE_TICKS_DEF,
    parameter int unsigned ADC_TIMEOUT  = ADC_TIMEOUT_DEF,
    parameter int unsigned DWELL_TICKS  = DWELL_TICKS_DEF,
    parameter int unsigned UMBRAL_1     = UMBRAL_1_DEF,
    parameter int unsigned UMBRAL_2     = UMBRAL_2_DEF,
    parameter int unsigned HYST         = HYST_DEF,
    parameter int unsigned DUTY_1       = DUTY_1_DEF,
    parameter int unsigned DUTY_2       = DUTY_2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc,
    input  logic       adc_done,
    input  logic [7:0] teclado,
    output logic       adc_start,
    output logic [1:0] nivel_obj,
    output logic [1:0] giro,
    output logic       pwm_out,
    output logic       fallo
);
    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(SAMPLE_TICKS + 1);
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    localparam int WW = $clog2(DWELL_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ADC_TIMEOUT - 1);
    localparam logic [WW-1:0] DWELL_MAX = WW'(DWELL_TICKS);
    localparam logic [7:0] U1 = 8'(UMBRAL_1);
    localparam logic [7:0] U2 = 8'(UMBRAL_2);
    localparam logic [7:0] D1 = 8'(DUTY_1);
    localparam logic [7:0] D2 = 8'(DUTY_2);

    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [TW-1:0] to_q, to_d;
    logic [WW-1:0] dwell_q, dwell_d;
    logic [1:0] estado_q, estado_d;
    logic [7:0] adc_l_q, adc_l_d, diff, duty;
    logic [8:0] suma;
    logic start_q, start_d, fallo_q, fallo_d, tick;
    nivel_t nivel_q, nivel_d, giro_q, giro_d, lvl_a, lvl_h, nivel_eval;

    assign tick = div_q == DIV_LAST;
    assign diff = adc_l_q > teclado ? adc_l_q - teclado : 8'd0;
    assign suma = {1'b0, diff} + 9'(HYST);
    assign lvl_a = nivel_de(diff, U1, U2);
    assign lvl_h = nivel_de(suma[8] ? 8'hFF : suma[7:0], U1, U2);
    // Rising demand acts at once; falling demand must clear the level by HYST before it is accepted
    assign nivel_eval = lvl_a > nivel_q ? lvl_a : (lvl_a < nivel_q && lvl_h < nivel_q) ? lvl_h : nivel_q;

    always_comb begin
        div_d    = tick ? '0 : div_q + DW'(1);
        estado_d = estado_q;
        samp_d   = samp_q;
        to_d     = to_q;
        adc_l_d  = adc_l_q;
        start_d  = 1'b0;
        fallo_d  = fallo_q;
        nivel_d  = nivel_q;
        giro_d   = giro_q;
        dwell_d  = tick && dwell_q != DWELL_MAX ? dwell_q + WW'(1) : dwell_q;
        if (giro_q != nivel_q && dwell_q == DWELL_MAX) begin
            giro_d  = giro_q < nivel_q ? giro_q + 2'd1 : giro_q - 2'd1;
            dwell_d = '0;
        end
        case (estado_q)
            ESPERA: if (tick) begin
                if (samp_q == SAMP_LAST) begin
                    estado_d = CONVERSION;
                    samp_d   = '0;
                    to_d     = '0;
                    start_d  = 1'b1;
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end
            CONVERSION: if (adc_done) begin
                estado_d = EVALUA;
                adc_l_d  = adc;
            end else if (tick) begin
                if (to_q == TO_LAST) begin
                    estado_d = ESPERA;
                    fallo_d  = 1'b1;
                    nivel_d  = NIVEL_3;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            EVALUA: begin
                estado_d = ESPERA;
                fallo_d  = 1'b0;
                nivel_d  = nivel_eval;
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            samp_q   <= '0;
            to_q     <= '0;
            dwell_q  <= '0;
            estado_q <= ESPERA;
            adc_l_q  <= '0;
            start_q  <= 1'b0;
            fallo_q  <= 1'b0;
            nivel_q  <= NIVEL_0;
            giro_q   <= NIVEL_0;
        end else begin
            div_q    <= div_d;
            samp_q   <= samp_d;
            to_q     <= to_d;
            dwell_q  <= dwell_d;
            estado_q <= estado_d;
            adc_l_q  <= adc_l_d;
            start_q  <= start_d;
            fallo_q  <= fallo_d;
            nivel_q  <= nivel_d;
            giro_q   <= giro_d;
        end
    end

    assign duty = duty_de(giro_q, D1, D2);

    generador_pwm u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

    assign adc_start = start_q;
    assign nivel_obj = nivel_q;
    assign giro      = giro_q;
    assign fallo     = fallo_q;
endmodule

// File: tb/tb_secuenciador_giro.sv
// tb_secuenciador_giro: directed scenarios checked every cycle against a behavioural model plus literal expectations
module tb_secuenciador_giro;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int AT = 3;
    localparam int DWT = 2;
    localparam int HY = 2;

    logic clk = 1'b0;
    logic rst, adc_done, adc_start, pwm_out, fallo;
    logic [7:0] adc, teclado;
    logic [1:0] nivel_obj, giro;

    int checks = 0;
    int errors = 0;
    int m_valid = 0;
    int m_t, m_ph, m_idle, m_conv, m_lat, m_obj, m_giro, m_dw, m_fallo, m_start, m_pc, m_duty, cyc;
    int acc = 0;
    int win_hi = -1;

    secuenciador_giro #(
        .TICK_DIV(TD), .SAMPLE_TICKS(ST), .ADC_TIMEOUT(AT), .DWELL_TICKS(DWT), .HYST(HY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc       (adc),
        .adc_done  (adc_done),
        .teclado   (teclado),
        .adc_start (adc_start),
        .nivel_obj (nivel_obj),
        .giro      (giro),
        .pwm_out   (pwm_out),
        .fallo     (fallo)
    );

    always #5 clk = ~clk;

    function automatic int lvl(int x);
        return x == 0 ? 0 : x <= 20 ? 1 : x <= 40 ? 2 : 3;
    endfunction

    function automatic int duty_of(int g);
        return g == 0 ? 0 : g == 1 ? 85 : g == 2 ? 170 : 255;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model state after the next clock edge, from the inputs that edge will sample
    task automatic model_next();
        int g0, tk, d, l, h;
        if (rst) begin
            m_t = 0; m_ph = 0; m_idle = 0; m_conv = 0; m_lat = 0; m_obj = 0; m_giro = 0;
            m_dw = 0; m_fallo = 0; m_start = 0; m_pc = 0; m_duty = 0; cyc = 0; m_valid = 1;
            return;
        end
        tk = (m_t == TD - 1) ? 1 : 0;
        m_t = (m_t + 1) % TD;
        cyc++;
        g0 = m_giro;
        if (m_giro != m_obj && m_dw == DWT) begin
            m_giro += (m_giro < m_obj) ? 1 : -1;
            m_dw = 0;
        end else if (tk == 1 && m_dw < DWT) m_dw++;
        if (m_pc == 255) m_duty = duty_of(g0);
        m_pc = (m_pc + 1) % 256;
        m_start = 0;
        if (m_ph == 0) begin
            if (tk == 1) begin
                m_idle++;
                if (m_idle == ST) begin
                    m_idle = 0; m_conv = 0; m_ph = 1; m_start = 1;
                end
            end
        end else if (m_ph == 1) begin
            if (adc_done) begin
                m_lat = int'(adc); m_ph = 2;
            end else if (tk == 1) begin
                m_conv++;
                if (m_conv == AT) begin
                    m_fallo = 1; m_obj = 3; m_ph = 0;
                end
            end
        end else begin
            d = m_lat > int'(teclado) ? m_lat - int'(teclado) : 0;
            l = lvl(d);
            h = lvl(d + HY > 255 ? 255 : d + HY);
            if (l > m_obj) m_obj = l;
            else if (l < m_obj && h < m_obj) m_obj = h;
            m_fallo = 0;
            m_ph = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_valid == 1) begin
            check("adc_start", 32'(adc_start), 32'(m_start));
            check("nivel_obj", 32'(nivel_obj), 32'(m_obj));
            check("giro", 32'(giro), 32'(m_giro));
            check("fallo", 32'(fallo), 32'(m_fallo));
            check("pwm_out", 32'(pwm_out), (m_duty == 255 || m_pc < m_duty) ? 32'd1 : 32'd0);
            if (m_pc == 0) acc = 0;
            acc += int'(pwm_out);
            if (m_pc == 255) win_hi = acc;
        end
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!adc_start && n < 200) begin
            step();
            n++;
        end
        check("adc_start_seen", 32'(adc_start), 32'd1);
    endtask

    task automatic conv_resp(input logic [7:0] val, input int d);
        repeat (d) step();
        adc = val;
        adc_done = 1'b1;
        step();
        adc_done = 1'b0;
        step();
    endtask

    task automatic conv(input logic [7:0] val, input int d);
        int n;
        wait_start(n);
        conv_resp(val, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        adc = 8'd0;
        adc_done = 1'b0;
        teclado = 8'd0;
        repeat (3) step();
        check("reset_nivel", 32'(nivel_obj), 32'd0);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        teclado = 8'd50;
        wait_start(n);
        check("first_start_delay", 32'(n), 32'd8);
        check("idle_giro", 32'(giro), 32'd0);
        check("idle_fallo", 32'(fallo), 32'd0);
        step();
        check("start_one_wide", 32'(adc_start), 32'd0);
        conv_resp(8'd75, 1);
        check("t2_nivel", 32'(nivel_obj), 32'd2);
        check("t2_giro_before_step", 32'(giro), 32'd0);
        step();
        check("t2_giro_first_step", 32'(giro), 32'd1);
        conv(8'd75, 2);
        check("t2_giro_second_step", 32'(giro), 32'd2);
        while (cyc < 600) conv(8'd75, 2);
        check("t2_pwm_high_per_256", 32'(win_hi), 32'd170);
        conv(8'd69, 2);
        check("t3_hyst_hold", 32'(nivel_obj), 32'd2);
        conv(8'd68, 2);
        check("t3_hyst_drop", 32'(nivel_obj), 32'd1);
        teclado = 8'd200;
        conv(8'd10, 2);
        check("diff0_hyst_hold", 32'(nivel_obj), 32'd1);
        wait_start(n);
        repeat (11) step();
        check("t5_fallo_before_timeout", 32'(fallo), 32'd0);
        step();
        check("t5_fallo", 32'(fallo), 32'd1);
        check("t5_nivel_failsafe", 32'(nivel_obj), 32'd3);
        repeat (700) step();
        check("t5_giro_max", 32'(giro), 32'd3);
        check("t5_pwm_constant_high", 32'(win_hi), 32'd256);
        teclado = 8'd50;
        conv(8'd75, 2);
        check("t5_fallo_cleared", 32'(fallo), 32'd0);
        check("t5_nivel_after_good", 32'(nivel_obj), 32'd2);
        conv(8'd55, 11);
        check("t6_coincident_fallo", 32'(fallo), 32'd0);
        check("t6_coincident_nivel", 32'(nivel_obj), 32'd1);
        wait_start(n);
        rst = 1'b1;
        step();
        check("t6_rst_start", 32'(adc_start), 32'd0);
        check("t6_rst_nivel", 32'(nivel_obj), 32'd0);
        check("t6_rst_giro", 32'(giro), 32'd0);
        check("t6_rst_fallo", 32'(fallo), 32'd0);
        check("t6_rst_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        step();
        adc = 8'd200;
        teclado = 8'd0;
        adc_done = 1'b1;
        step();
        adc_done = 1'b0;
        repeat (3) step();
        check("t6_late_done_ignored", 32'(nivel_obj), 32'd0);
        teclado = 8'd200;
        conv(8'd10, 2);
        check("t4_underflow_nivel", 32'(nivel_obj), 32'd0);
        while (cyc < 600) conv(8'd10, 2);
        check("t4_giro_zero", 32'(giro), 32'd0);
        check("t4_pwm_constant_low", 32'(win_hi), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
